pregfile_mp: RTL

PREGFILE_MP -- requirements
Module: pregfile_mp

---
 rtl/pregfile_mp_pkg.sv | 18 +
 rtl/pregfile_mp_if.sv | 36 +++
 rtl/preg_busytable.sv | 42 ++++
 rtl/pregfile_mp.sv | 110 +++++++++++
 4 files changed

// File: rtl/pregfile_mp_pkg.sv
// Shared backend constants for the physical register file: default geometry,
// index-width derivation and the hard-wired zero register.
package pregfile_mp_pkg;

  localparam int PREG_LENGTH   = 64;
  localparam int PREG_RANGE    = PREG_LENGTH - 1;
  localparam int PREG_DATA_W   = 64;
  localparam int PREG_NUM_RD   = 4;
  localparam int PREG_NUM_WR   = 2;
  localparam int PREG_READ_LAT = 0;
  localparam int PREG_ZERO     = 0;

  // At least one index bit even for a two-entry file.
  function automatic int preg_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pregfile_mp_if.sv
// Read, writeback, allocation and flush bundle for the physical register file.
// No handshake: a port acts whenever its enable is high in the cycle; rd_ready only reports operand availability.
interface pregfile_mp_if
  import pregfile_mp_pkg::*;
#(
  parameter int NUM_PREGS = PREG_LENGTH,
  parameter int DATA_W    = PREG_DATA_W,
  parameter int NUM_RD    = PREG_NUM_RD,
  parameter int NUM_WR    = PREG_NUM_WR
);
  localparam int IDX_W = preg_idx_w(NUM_PREGS);

  logic [NUM_RD-1:0]             rd_en;
  logic [NUM_RD-1:0][IDX_W-1:0]  rd_idx;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_ready;

  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][IDX_W-1:0]  wr_idx;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;

  logic [NUM_WR-1:0]             alloc_en;
  logic [NUM_WR-1:0][IDX_W-1:0]  alloc_idx;

  logic                          flush;

  modport master (
    output rd_en, rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, flush,
    input  rd_data, rd_ready
  );

  modport slave (
    input  rd_en, rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, flush,
    output rd_data, rd_ready
  );
endinterface

// File: rtl/preg_busytable.sv
// One busy bit per physical register: set on rename allocation, cleared on
// writeback, wiped by a pipeline flush.
module preg_busytable
  import pregfile_mp_pkg::*;
#(
  parameter int NUM_PREGS = PREG_LENGTH,
  parameter int NUM_WR    = PREG_NUM_WR,
  localparam int IDX_W    = preg_idx_w(NUM_PREGS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_WR-1:0]            set_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0] set_idx,
  input  logic [NUM_WR-1:0]            clr_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0] clr_idx,
  input  logic                         flush,
  output logic [NUM_PREGS-1:0]         busy
);

  logic [NUM_PREGS-1:0] busy_q, busy_d;

  // Clears are applied before sets so an allocation beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (clr_en[w]) busy_d[clr_idx[w]] = 1'b0;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (set_en[w]) busy_d[set_idx[w]] = 1'b1;
    end
    if (flush) busy_d = '0;
    busy_d[PREG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/pregfile_mp.sv
// Multi-ported physical register file with writeback bypass, busy tracking
// and an optional registered read stage.
module pregfile_mp
  import pregfile_mp_pkg::*;
#(
  parameter int NUM_PREGS = PREG_LENGTH,
  parameter int DATA_W    = PREG_DATA_W,
  parameter int NUM_RD    = PREG_NUM_RD,
  parameter int NUM_WR    = PREG_NUM_WR,
  parameter int READ_LAT  = PREG_READ_LAT
) (
  input  logic          clock,
  input  logic          reset_n,
  pregfile_mp_if.slave  bus
);

  localparam int IDX_W = preg_idx_w(NUM_PREGS);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(PREG_ZERO);

  logic [DATA_W-1:0]    mem_q [NUM_PREGS];
  logic [DATA_W-1:0]    mem_d [NUM_PREGS];
  logic [NUM_PREGS-1:0] busy;

  // Ascending port order lets the highest-numbered writer win; mem_d doubles as the bypass source.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w] && (bus.wr_idx[w] != ZERO_IDX)) mem_d[bus.wr_idx[w]] = bus.wr_data[w];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [NUM_WR-1:0] alloc_ok;
  always_comb begin
    alloc_ok = '0;
    for (int w = 0; w < NUM_WR; w++) alloc_ok[w] = bus.alloc_en[w] && (bus.alloc_idx[w] != ZERO_IDX);
  end

  preg_busytable #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_WR    (NUM_WR)
  ) u_busy (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (alloc_ok),
    .set_idx (bus.alloc_idx),
    .clr_en  (bus.wr_en),
    .clr_idx (bus.wr_idx),
    .flush   (bus.flush),
    .busy    (busy)
  );

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [DATA_W-1:0] data_now;
    logic              ready_now;
    logic              wake;

    // A same-cycle writeback to the read index wakes the operand early.
    always_comb begin
      wake = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_idx[w] == bus.rd_idx[r])) wake = 1'b1;
      end
      data_now  = mem_d[bus.rd_idx[r]];
      ready_now = !busy[bus.rd_idx[r]] || wake;
      if (bus.rd_idx[r] == ZERO_IDX) begin
        data_now  = '0;
        ready_now = 1'b1;
      end
    end

    if (READ_LAT == 0) begin : g_lat0
      assign bus.rd_data[r]  = bus.rd_en[r] ? data_now : '0;
      assign bus.rd_ready[r] = ready_now;
    end else begin : g_lat1
      logic [DATA_W-1:0] rd_data_q, rd_data_d;
      logic              rd_ready_q, rd_ready_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_ready_d = rd_ready_q;
        if (bus.rd_en[r]) begin
          rd_data_d  = data_now;
          rd_ready_d = ready_now;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rd_data_q  <= '0;
          rd_ready_q <= 1'b1;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_ready_q <= rd_ready_d;
        end
      end

      assign bus.rd_data[r]  = rd_data_q;
      assign bus.rd_ready[r] = rd_ready_q;
    end
  end

endmodule
